// File: rtl/ring_fifo_pkg.sv
// rtl/ring_fifo_pkg.sv - shared sizing helpers for the run-time-depth ring FIFO
package ring_fifo_pkg;

  localparam int unsigned DEFAULT_AW = 3;
  localparam int unsigned DEFAULT_DW = 8;

  function automatic int unsigned depth_max(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ring_fifo_wrap_ptr.sv
// rtl/ring_fifo_wrap_ptr.sv - circular index that wraps to zero after reaching max
module wrap_ptr #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [AW-1:0] max,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == max) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/ring_fifo.sv
// rtl/ring_fifo.sv - first-word-fall-through FIFO whose depth (max+1) is set at run time
module ring_fifo
  import ring_fifo_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] max,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned DEPTH_MAX = depth_max(AW);
  localparam logic [AW:0] ONE       = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [0:DEPTH_MAX-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] max_q;
  logic [AW:0]   depth;
  logic          push;
  logic          pop;

  assign depth     = {1'b0, max_q} + ONE;
  assign full      = (count == depth);
  assign empty     = (count == '0);
  assign in_ready  = ~rst & ~full;
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  wrap_ptr #(.AW(AW)) u_wr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .max (max_q),
    .ptr (wr_ptr)
  );

  wrap_ptr #(.AW(AW)) u_rd (
    .clk (clk),
    .rst (rst),
    .inc (pop & ~rst),
    .max (max_q),
    .ptr (rd_ptr)
  );

  // push is already blocked during rst through in_ready, so storage needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // depth may only change while nothing is stored; pointers are equal then
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= max;
    end else if (empty && !push) begin
      max_q <= max;
    end
  end

endmodule

// File: tb/tb_ring_fifo.sv
// tb/tb_ring_fifo.sv - table vectors plus scoreboarded sequences for ring_fifo
module tb_ring_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] max;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       full;
  logic       empty;

  int n_cmp = 0;
  int n_bad = 0;

  ring_fifo #(.AW(3), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .max       (max),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    logic [2:0] mx;
    bit         iv;
    logic [7:0] din;
    bit         ordy;
    int         cnt;
    bit         fl;
    bit         em;
    bit         ir;
    bit         ov;
    int         dout;
    int         rdp;
  } vec_t;

  vec_t tbl [13];

  logic [7:0] sb [$];
  int m_maxq;
  int m_wr;
  int m_rd;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, int mx, bit iv, int din, bit ordy,
                              int cnt, bit fl, bit em, bit ir, bit ov, int dout, int rdp);
    vec_t v;
    v.r = r; v.mx = 3'(mx); v.iv = iv; v.din = 8'(din); v.ordy = ordy;
    v.cnt = cnt; v.fl = fl; v.em = em; v.ir = ir; v.ov = ov; v.dout = dout; v.rdp = rdp;
    return v;
  endfunction

  task automatic cycle(input bit r, input int mx, input bit iv, input int d, input bit ordy);
    bit ex_full, ex_empty, ex_ir, push_ok, pop_ok, was_empty;
    rst = r; max = 3'(mx); in_valid = iv; in_data = 8'(d); out_ready = ordy;
    #2;
    ex_full  = (sb.size() == m_maxq + 1);
    ex_empty = (sb.size() == 0);
    ex_ir    = !r && !ex_full;
    chk("count", int'(count), sb.size());
    chk("full", int'(full), int'(ex_full));
    chk("empty", int'(empty), int'(ex_empty));
    chk("in_ready", int'(in_ready), int'(ex_ir));
    chk("out_valid", int'(out_valid), int'(!ex_empty));
    chk("max_q", int'(dut.max_q), m_maxq);
    chk("wr_ptr", int'(dut.wr_ptr), m_wr);
    chk("rd_ptr", int'(dut.rd_ptr), m_rd);
    push_ok   = iv && ex_ir;
    pop_ok    = !ex_empty && ordy && !r;
    was_empty = ex_empty;
    if (pop_ok) chk("out_data", int'(out_data), int'(sb[0]));
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      m_maxq = mx; m_wr = 0; m_rd = 0;
    end else begin
      if (pop_ok) begin
        void'(sb.pop_front());
        m_rd = (m_rd == m_maxq) ? 0 : m_rd + 1;
      end
      if (push_ok) begin
        sb.push_back(8'(d));
        m_wr = (m_wr == m_maxq) ? 0 : m_wr + 1;
      end
      if (was_empty && !push_ok) m_maxq = mx;
    end
  endtask

  initial begin
    rst = 1'b1; max = 3'd4; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    tbl[0] = mk(1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[1] = mk(0, 4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      tbl[2+i] = mk(0, 4, 1, 'h10 + i, 0, i + 1, i == 4, 0, i != 4, 1, 'h10, 0);
    tbl[7] = mk(0, 4, 1, 'h15, 0, 5, 1, 0, 0, 1, 'h10, 0);
    for (int k = 0; k < 5; k++)
      tbl[8+k] = mk(0, 4, 0, 0, 1, 4 - k, 0, k == 4, 1, k != 4, 'h11 + k, (k == 4) ? 0 : k + 1);

    // tests 1 and 2: fill depth-5 FIFO, reject a sixth word, then drain in order
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r; max = tbl[i].mx; in_valid = tbl[i].iv;
      in_data = tbl[i].din; out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.count", i), int'(count), tbl[i].cnt);
      chk($sformatf("v%0d.full", i), int'(full), int'(tbl[i].fl));
      chk($sformatf("v%0d.empty", i), int'(empty), int'(tbl[i].em));
      chk($sformatf("v%0d.in_ready", i), int'(in_ready), int'(tbl[i].ir));
      chk($sformatf("v%0d.out_valid", i), int'(out_valid), int'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("v%0d.out_data", i), int'(out_data), tbl[i].dout);
      chk($sformatf("v%0d.rd_ptr", i), int'(dut.rd_ptr), tbl[i].rdp);
    end

    sb.delete();
    m_maxq = 4; m_wr = 0; m_rd = 0;

    // test 3: depth 3, streaming push and pop every cycle
    cycle(0, 2, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 2, 1, i, 1);
    cycle(0, 2, 0, 0, 1);
    cycle(0, 2, 0, 0, 0);

    // test 4: depth change ignored while non-empty, taken once drained
    cycle(0, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 7, 1, 'h30 + i, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 'h40, 0);
    cycle(0, 1, 1, 'h41, 0);
    cycle(0, 1, 1, 'h42, 0);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);

    // test 5: single-entry FIFO
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 'hAA, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 'hBB, 1);
    cycle(0, 0, 1, 'hBB, 1);
    cycle(0, 0, 1, 'hCC, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // test 6: reset mid-operation discards contents and the word offered during reset
    cycle(0, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 7, 1, 'h60 + i, 0);
    cycle(1, 7, 1, 'hEE, 1);
    cycle(0, 7, 0, 0, 1);
    cycle(0, 7, 1, 'h55, 0);
    cycle(0, 7, 0, 0, 1);
    cycle(0, 7, 0, 0, 0);

    chk("end_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
